// File: rtl/fft_sum_round_sat.sv
// Output conditioning after complex_adder: optional /2 round-half-up, saturate to WIDTH,
// 2-entry skid buffer, frame tracking with sticky saturation. FFT_SAT_STATS_EN adds sat_count.
module fft_sum_round_sat #(
  parameter int  WIDTH     = 16,
  parameter int  FRAME_MAX = 1024,
  localparam int CW        = $clog2(FRAME_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_real,
  input  logic [WIDTH:0]   in_imag,
  input  logic             in_last,
  input  logic             scale_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  output logic             out_last,
  output logic             out_sat,
  output logic             frame_done,
`ifdef FFT_SAT_STATS_EN
  output logic [CW-1:0]    sat_count,
`endif
  output logic             frame_sat
);

  localparam logic signed [WIDTH+1:0] ONE  = (WIDTH+2)'(1);
  localparam logic signed [WIDTH+1:0] SMAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SMIN = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ACTIVE} frame_state_e;

  typedef struct packed {
    logic             last;
    logic             sat;
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } entry_t;

  // Returns {sat_flag, saturated WIDTH-bit value}.
  function automatic logic [WIDTH:0] condition(input logic [WIDTH:0] x, input logic scale);
    logic signed [WIDTH+1:0] ext;
    logic signed [WIDTH+1:0] y;
    logic [WIDTH:0]          res;
    ext = signed'({x[WIDTH], x});
    y   = scale ? ((ext + ONE) >>> 1) : ext;
    if (y > SMAX) begin
      res = {1'b1, SMAX[WIDTH-1:0]};
    end else if (y < SMIN) begin
      res = {1'b1, SMIN[WIDTH-1:0]};
    end else begin
      res = {1'b0, y[WIDTH-1:0]};
    end
    return res;
  endfunction

  entry_t        mem_q [2];
  entry_t        wr_entry;
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic          in_ready_q;
  frame_state_e  state_q, state_d;
  logic [CW-1:0] smp_cnt_q, smp_cnt_d, smp_base;
  logic          sticky_q, sticky_d;
  logic          push, pop, frame_end;
  logic [WIDTH:0] re_c, im_c;
`ifdef FFT_SAT_STATS_EN
  logic [CW-1:0] sat_cnt_q, sat_cnt_d;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = (count_q != 2'd0);
  assign out_real   = mem_q[rd_ptr_q].re;
  assign out_imag   = mem_q[rd_ptr_q].im;
  assign out_last   = out_valid & mem_q[rd_ptr_q].last;
  assign out_sat    = out_valid & mem_q[rd_ptr_q].sat;
  assign push       = in_valid & in_ready_q;
  assign pop        = out_valid & out_ready;
  assign frame_done = pop & out_last;
  // The closing beat's own saturation is folded in here, before the sticky flag sees it.
  assign frame_sat  = frame_done & (sticky_q | out_sat);
`ifdef FFT_SAT_STATS_EN
  assign sat_count  = sat_cnt_q + CW'(pop & out_sat);
`endif

  always_comb begin
    re_c          = condition(in_real, scale_en);
    im_c          = condition(in_imag, scale_en);
    smp_base      = (state_q == IDLE) ? '0 : smp_cnt_q;
    frame_end     = in_last | (smp_base == CW'(FRAME_MAX - 1));
    wr_entry.last = frame_end;
    wr_entry.sat  = re_c[WIDTH] | im_c[WIDTH];
    wr_entry.re   = re_c[WIDTH-1:0];
    wr_entry.im   = im_c[WIDTH-1:0];

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end

    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    if (push) begin
      if (frame_end) begin
        state_d   = IDLE;
        smp_cnt_d = '0;
      end else begin
        state_d   = ACTIVE;
        smp_cnt_d = smp_base + CW'(1);
      end
    end

    sticky_d = frame_done ? 1'b0 : (sticky_q | (pop & out_sat));
`ifdef FFT_SAT_STATS_EN
    sat_cnt_d = frame_done ? '0 : (sat_cnt_q + CW'(pop & out_sat));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      state_q    <= IDLE;
      smp_cnt_q  <= '0;
      sticky_q   <= 1'b0;
`ifdef FFT_SAT_STATS_EN
      sat_cnt_q  <= '0;
`endif
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      // Registered ready: a beat is only accepted when a slot is guaranteed free.
      in_ready_q <= (count_d != 2'd2);
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      sticky_q   <= sticky_d;
`ifdef FFT_SAT_STATS_EN
      sat_cnt_q  <= sat_cnt_d;
`endif
    end
  end

endmodule
